// File: rtl/storage_byte_view_if.sv
// Bus bundle for storage_byte_view: address/write/byte-select inputs and
// the read, LED and scan-status outputs.
// Strobe semantics: there is no valid/ready pair. Mem_Write is a single-cycle
// strobe sampled on the rising clock edge; it is accepted whenever Busy is 0
// and silently dropped while Busy is 1. Reads need no strobe: Mem_Rdata/LED
// reflect the address/CS presented before the previous edge.
interface storage_byte_view_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  localparam int NB   = DATA_W / 8;
  localparam int CS_W = (NB > 1) ? $clog2(NB) : 1;

  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Write;
  logic [DATA_W-1:0] Mem_Wdata;
  logic [NB-1:0]     Byte_En;
  logic [CS_W-1:0]   CS;
  logic              Scan_En;
  logic              Busy;
  logic [DATA_W-1:0] Mem_Rdata;
  logic [7:0]        LED;
  logic [ADDR_W-1:0] Scan_Addr;
  logic [CS_W-1:0]   Scan_CS;
  logic [1:0]        State;

  modport master (
    output Mem_Addr, Mem_Write, Mem_Wdata, Byte_En, CS, Scan_En,
    input  Busy, Mem_Rdata, LED, Scan_Addr, Scan_CS, State
  );

  modport slave (
    input  Mem_Addr, Mem_Write, Mem_Wdata, Byte_En, CS, Scan_En,
    output Busy, Mem_Rdata, LED, Scan_Addr, Scan_CS, State
  );
endinterface

// File: rtl/storage_byte_view.sv
// Word-addressed storage with byte-lane writes, registered read and an LED
// byte viewer. After reset a fill FSM writes a counting byte pattern into
// every word; afterwards the viewer runs in manual (CS-selected) or auto-scan
// mode. State is exposed on bus.State (0=FILL, 1=MANUAL, 2=SCAN).
module storage_byte_view #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int SCAN_DIV = 4
) (
  input logic                Clk,
  input logic                Reset,
  storage_byte_view_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int CS_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] fill_ptr;
  logic [DIV_W-1:0]  div_cnt;
  logic [CS_W-1:0]   cs_q;
  logic [ADDR_W-1:0] scan_addr;
  logic [CS_W-1:0]   scan_cs;
  logic              busy;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] fill_word;
  logic [ADDR_W-1:0] read_addr;
  logic [31:0]       lane_val;
  logic [DATA_W-1:0] mem [DEPTH];

  // Fill pattern: byte k of word a is (a*NB + k) mod 256.
  always_comb begin
    fill_word = '0;
    lane_val  = '0;
    for (int k = 0; k < NB; k++) begin
      lane_val = 32'(int'(fill_ptr) * NB + k);
      fill_word[8*k +: 8] = lane_val[7:0];
    end
  end

  // Read address follows the scan pointer in SCAN, the bus address otherwise.
  always_comb begin
    read_addr = (state == SCAN) ? scan_addr : bus.Mem_Addr;
  end

  // Storage array: fill writes whole words, user writes honour byte enables.
  always_ff @(posedge Clk) begin
    if (!Reset && state == FILL) begin
      mem[fill_ptr] <= fill_word;
    end else if (!Reset && bus.Mem_Write) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.Byte_En[k]) mem[bus.Mem_Addr][8*k +: 8] <= bus.Mem_Wdata[8*k +: 8];
      end
    end
  end

  // Mode FSM with fill pointer, registered read, lane select and scan counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= FILL;
      fill_ptr  <= '0;
      busy      <= 1'b1;
      rdata     <= '0;
      cs_q      <= '0;
      scan_addr <= '0;
      scan_cs   <= '0;
      div_cnt   <= '0;
    end else begin
      case (state)
        FILL: begin
          fill_ptr <= fill_ptr + 1'b1;
          if (fill_ptr == ADDR_W'(DEPTH - 1)) begin
            state <= MANUAL;
            busy  <= 1'b0;
          end
        end
        MANUAL: begin
          rdata <= mem[read_addr];
          cs_q  <= bus.CS;
          if (bus.Scan_En) state <= SCAN;
        end
        SCAN: begin
          // Read-first: rdata takes the pre-write word on a same-edge write.
          rdata <= mem[read_addr];
          cs_q  <= scan_cs;
          if (!bus.Scan_En) begin
            state     <= MANUAL;
            scan_addr <= '0;
            scan_cs   <= '0;
            div_cnt   <= '0;
          end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
            div_cnt <= '0;
            if (scan_cs == CS_W'(NB - 1)) begin
              scan_cs   <= '0;
              scan_addr <= scan_addr + 1'b1;
            end else begin
              scan_cs <= scan_cs + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state    <= FILL;
          fill_ptr <= '0;
          busy     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.Busy      = busy;
  assign bus.Mem_Rdata = rdata;
  assign bus.LED       = busy ? 8'h00 : rdata[cs_q*8 +: 8];
  assign bus.Scan_Addr = scan_addr;
  assign bus.Scan_CS   = scan_cs;
  assign bus.State     = state;
endmodule

// File: tb/tb_storage_byte_view.sv
// Bench for storage_byte_view at default parameters (32-bit, 64 words,
// scan divider 4). A word model tracks memory contents; expected LED/read
// values are queued when inputs are driven and popped after the clock edge.
module tb_storage_byte_view;
  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic [31:0] model_mem [64];
  logic [7:0]  exp_led_q [$];
  logic [31:0] exp_rd_q [$];

  storage_byte_view_if #(.DATA_W(32), .ADDR_W(6)) bus ();

  storage_byte_view #(.DATA_W(32), .ADDR_W(6), .SCAN_DIV(4)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] pat_word(int a);
    logic [31:0] w;
    int v;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      v = a * 4 + k;
      w[8*k +: 8] = v[7:0];
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_fill();
    for (int a = 0; a < 64; a++) model_mem[a] = pat_word(a);
  endtask

  task automatic model_write(int a, logic [31:0] d, logic [3:0] be);
    for (int k = 0; k < 4; k++)
      if (be[k]) model_mem[a][8*k +: 8] = d[8*k +: 8];
  endtask

  // Counts Busy-high samples (including the current one) while pulsing writes.
  task automatic wait_fill(string name);
    int n = 0;
    int guard = 0;
    while (bus.Busy === 1'b1 && guard < 200) begin
      n++;
      bus.Mem_Write = 1'b1;
      bus.Mem_Addr  = 6'($urandom_range(0, 63));
      bus.Mem_Wdata = $urandom;
      bus.Byte_En   = 4'hF;
      tick();
      guard++;
    end
    bus.Mem_Write = 1'b0;
    total_cnt++;
    if (n !== 64) $display("FAIL %s busy_len got %0d exp 64", name, n);
    else pass_cnt++;
  endtask

  // Reads every word with a random CS and checks Mem_Rdata and LED.
  task automatic sweep_read(string name);
    logic [31:0] rd;
    logic [7:0]  ld;
    int c;
    for (int a = 0; a < 64; a++) begin
      c = $urandom_range(0, 3);
      bus.Mem_Addr = 6'(a);
      bus.CS       = 2'(c);
      exp_rd_q.push_back(model_mem[a]);
      exp_led_q.push_back(model_mem[a][8*c +: 8]);
      tick();
      rd = exp_rd_q.pop_front();
      ld = exp_led_q.pop_front();
      total_cnt++;
      if (bus.Mem_Rdata !== rd) $display("FAIL %s rdata a=%0d got %h exp %h", name, a, bus.Mem_Rdata, rd);
      else pass_cnt++;
      total_cnt++;
      if (bus.LED !== ld) $display("FAIL %s led a=%0d cs=%0d got %h exp %h", name, a, c, bus.LED, ld);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Mem_Write = 1'b0;
    bus.Mem_Addr  = '0;
    bus.Mem_Wdata = '0;
    bus.Byte_En   = '0;
    bus.CS        = '0;
    bus.Scan_En   = 1'b0;
    tick();
    total_cnt++;
    if (bus.Busy !== 1'b1) $display("FAIL reset busy got %b exp 1", bus.Busy); else pass_cnt++;
    total_cnt++;
    if (bus.LED !== 8'h00) $display("FAIL reset led got %h exp 00", bus.LED); else pass_cnt++;
    total_cnt++;
    if (bus.Mem_Rdata !== 32'h0) $display("FAIL reset rdata got %h exp 0", bus.Mem_Rdata); else pass_cnt++;
    total_cnt++;
    if (bus.Scan_Addr !== 6'd0) $display("FAIL reset scan_addr got %0d exp 0", bus.Scan_Addr); else pass_cnt++;
    total_cnt++;
    if (bus.Scan_CS !== 2'd0) $display("FAIL reset scan_cs got %0d exp 0", bus.Scan_CS); else pass_cnt++;
    rst = 1'b0;
    model_fill();
    wait_fill("fill");
  endtask

  task automatic test_manual();
    logic [5:0] addr_tab [9] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd1, 6'd1, 6'd1, 6'd1, 6'd63};
    logic [1:0] cs_tab   [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [7:0] led_tab  [9] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hFF};
    logic [7:0] ld;
    for (int i = 0; i < 9; i++) begin
      bus.Mem_Addr = addr_tab[i];
      bus.CS       = cs_tab[i];
      exp_led_q.push_back(led_tab[i]);
      tick();
      ld = exp_led_q.pop_front();
      total_cnt++;
      if (bus.LED !== ld) $display("FAIL manual led a=%0d cs=%0d got %h exp %h", addr_tab[i], cs_tab[i], bus.LED, ld);
      else pass_cnt++;
    end
    sweep_read("pattern");
  endtask

  task automatic do_write(int a, logic [31:0] d, logic [3:0] be);
    bus.Mem_Addr  = 6'(a);
    bus.Mem_Wdata = d;
    bus.Byte_En   = be;
    bus.Mem_Write = 1'b1;
    tick();
    bus.Mem_Write = 1'b0;
    model_write(a, d, be);
  endtask

  task automatic test_byte_lane();
    logic [31:0] rd;
    do_write(5, 32'hA5A5A5A5, 4'b0010);
    bus.Mem_Addr = 6'd5;
    exp_rd_q.push_back(32'h1716A514);
    tick();
    rd = exp_rd_q.pop_front();
    total_cnt++;
    if (bus.Mem_Rdata !== rd) $display("FAIL lane_write got %h exp %h", bus.Mem_Rdata, rd); else pass_cnt++;
    do_write(5, 32'h5A5A5A5A, 4'b0000);
    bus.Mem_Addr = 6'd5;
    exp_rd_q.push_back(32'h1716A514);
    tick();
    rd = exp_rd_q.pop_front();
    total_cnt++;
    if (bus.Mem_Rdata !== rd) $display("FAIL lane_none got %h exp %h", bus.Mem_Rdata, rd); else pass_cnt++;
    for (int i = 0; i < 12; i++)
      do_write($urandom_range(16, 62), $urandom, 4'($urandom_range(0, 15)));
    sweep_read("random_write");
  endtask

  task automatic test_read_during_write();
    logic [31:0] rd;
    bus.Mem_Addr  = 6'd9;
    bus.Mem_Wdata = 32'hDEADBEEF;
    bus.Byte_En   = 4'hF;
    bus.Mem_Write = 1'b1;
    exp_rd_q.push_back(32'h27262524);
    tick();
    bus.Mem_Write = 1'b0;
    model_write(9, 32'hDEADBEEF, 4'hF);
    rd = exp_rd_q.pop_front();
    total_cnt++;
    if (bus.Mem_Rdata !== rd) $display("FAIL rdw_old got %h exp %h", bus.Mem_Rdata, rd); else pass_cnt++;
    exp_rd_q.push_back(32'hDEADBEEF);
    tick();
    rd = exp_rd_q.pop_front();
    total_cnt++;
    if (bus.Mem_Rdata !== rd) $display("FAIL rdw_new got %h exp %h", bus.Mem_Rdata, rd); else pass_cnt++;
  endtask

  task automatic test_scan();
    int sa = 0;
    int sc = 0;
    int dv = 0;
    logic [7:0] ld;
    bus.Mem_Addr = 6'd0;
    bus.CS       = 2'd0;
    bus.Scan_En  = 1'b1;
    tick();
    for (int i = 0; i < 1044; i++) begin
      exp_led_q.push_back(model_mem[sa][8*sc +: 8]);
      if (sa == 63 && sc == 3) begin
        total_cnt++;
        if (model_mem[63][31:24] !== 8'hFF) $display("FAIL scan_last_model got %h exp ff", model_mem[63][31:24]);
        else pass_cnt++;
      end
      if (sa == 10 && sc == 0 && dv == 0) begin
        bus.Mem_Addr  = 6'd10;
        bus.Mem_Wdata = 32'h11223344;
        bus.Byte_En   = 4'hF;
        bus.Mem_Write = 1'b1;
        model_write(10, 32'h11223344, 4'hF);
      end
      tick();
      bus.Mem_Write = 1'b0;
      ld = exp_led_q.pop_front();
      total_cnt++;
      if (bus.LED !== ld) $display("FAIL scan_led i=%0d a=%0d cs=%0d got %h exp %h", i, sa, sc, bus.LED, ld);
      else pass_cnt++;
      if (dv == 3) begin
        dv = 0;
        if (sc == 3) begin
          sc = 0;
          sa = (sa + 1) % 64;
        end else begin
          sc++;
        end
      end else begin
        dv++;
      end
      total_cnt++;
      if (bus.Scan_Addr !== 6'(sa)) $display("FAIL scan_addr i=%0d got %0d exp %0d", i, bus.Scan_Addr, sa);
      else pass_cnt++;
      total_cnt++;
      if (bus.Scan_CS !== 2'(sc)) $display("FAIL scan_cs i=%0d got %0d exp %0d", i, bus.Scan_CS, sc);
      else pass_cnt++;
    end
    bus.Scan_En = 1'b0;
    tick();
    total_cnt++;
    if (bus.Scan_Addr !== 6'd0) $display("FAIL scan_exit addr got %0d exp 0", bus.Scan_Addr); else pass_cnt++;
    total_cnt++;
    if (bus.Scan_CS !== 2'd0) $display("FAIL scan_exit cs got %0d exp 0", bus.Scan_CS); else pass_cnt++;
    bus.Mem_Addr = 6'd10;
    bus.CS       = 2'd0;
    exp_led_q.push_back(8'h44);
    tick();
    ld = exp_led_q.pop_front();
    total_cnt++;
    if (bus.LED !== ld) $display("FAIL scan_exit manual led got %h exp %h", bus.LED, ld); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bus.Scan_En = 1'b1;
    for (int i = 0; i < 37; i++) tick();
    rst = 1'b1;
    bus.Scan_En = 1'b0;
    tick();
    total_cnt++;
    if (bus.Busy !== 1'b1) $display("FAIL midscan busy got %b exp 1", bus.Busy); else pass_cnt++;
    total_cnt++;
    if (bus.LED !== 8'h00) $display("FAIL midscan led got %h exp 00", bus.LED); else pass_cnt++;
    total_cnt++;
    if (bus.Scan_Addr !== 6'd0) $display("FAIL midscan scan_addr got %0d exp 0", bus.Scan_Addr); else pass_cnt++;
    total_cnt++;
    if (bus.Scan_CS !== 2'd0) $display("FAIL midscan scan_cs got %0d exp 0", bus.Scan_CS); else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total_cnt++;
      if (bus.Busy !== 1'b1) $display("FAIL midfill busy i=%0d got %b exp 1", i, bus.Busy); else pass_cnt++;
    end
    rst = 1'b1;
    tick();
    total_cnt++;
    if (bus.Busy !== 1'b1) $display("FAIL refill busy got %b exp 1", bus.Busy); else pass_cnt++;
    total_cnt++;
    if (bus.LED !== 8'h00) $display("FAIL refill led got %h exp 00", bus.LED); else pass_cnt++;
    rst = 1'b0;
    model_fill();
    wait_fill("refill");
    sweep_read("refill_pattern");
  endtask

  initial begin
    test_reset();
    test_manual();
    test_byte_lane();
    test_read_during_write();
    test_scan();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
